// File: rtl/package_bus.sv
// Shared definitions for the bus <-> stream mux/demux pair: header layout,
// serializer state encoding and the frame-length helper used by both ends.
package package_bus;

  localparam int HDR_ADR = 0;

  typedef enum logic [1:0] {
    IDL,
    HDR,
    ADR,
    DAT
  } bus_ser_st_t;

  // Beats in one frame: header, optional address beats, data beats.
  function automatic int frame_len(int aw, int dw, int sw, bit a);
    return 1 + (a ? aw / sw : 0) + dw / sw;
  endfunction

endpackage

// File: rtl/bus_stream_ser.sv
// Bus-to-stream serializer: captures one address/data word at a time and emits
// it as a framed sequence of SW-bit beats, dropping the address when sequential.
module bus_stream_ser
  import package_bus::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int SW  = 8,
  parameter int CMP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bsi_vld,
  input  logic [AW-1:0] bsi_adr,
  input  logic [DW-1:0] bsi_dat,
  output logic          bsi_rdy,
  output logic          sto_vld,
  output logic [SW-1:0] sto_bus,
  output logic          sto_lst,
  input  logic          sto_rdy
);

  localparam int AB = AW / SW;
  localparam int DB = DW / SW;
  localparam int MB = (AB > DB) ? AB : DB;
  localparam int CW = (MB > 1) ? $clog2(MB) : 1;

  if (SW < 2) begin : g_chk_sw
    $error("bus_stream_ser: SW must be at least 2");
  end
  if (AW % SW != 0) begin : g_chk_aw
    $error("bus_stream_ser: AW must be a multiple of SW");
  end
  if (DW % SW != 0) begin : g_chk_dw
    $error("bus_stream_ser: DW must be a multiple of SW");
  end

  bus_ser_st_t      state_q;
  logic [CW-1:0]    cnt_q;
  logic [AW+DW-1:0] shr_q;
  logic             a_q;
  logic [AW-1:0]    prv_adr_q;
  logic             prv_vld_q;
  logic             run_q;
  logic             sto_vld_q;
  logic [SW-1:0]    sto_bus_q;
  logic             sto_lst_q;

  logic             xfer;
  logic             dat_end;
  logic             cap;
  logic             hit;
  logic [AW-1:0]    nxt_adr;
  logic [SW-1:0]    hdr_beat;
  logic [AW+DW-1:0] shr_cap;
  logic [AW+DW-1:0] shr_nxt;
  logic [SW-1:0]    beat;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    hdr_beat          = '0;
    xfer              = sto_vld_q & sto_rdy;
    dat_end           = (state_q == DAT) && (cnt_q == CW'(DB - 1));
    // The sto_rdy -> bsi_rdy path lets a new word be captured on the last beat.
    bsi_rdy           = run_q & ((state_q == IDL) | (dat_end & sto_rdy));
    cap               = bsi_vld & bsi_rdy;
    nxt_adr           = prv_adr_q + 1'b1;
    hit               = (CMP != 0) && prv_vld_q && (bsi_adr == nxt_adr);
    hdr_beat[HDR_ADR] = !hit;
    // A compressed word loads data into the low end so DAT follows HDR directly.
    shr_cap           = hit ? {{AW{1'b0}}, bsi_dat} : {bsi_dat, bsi_adr};
    shr_nxt           = shr_q >> SW;
    beat              = shr_q[SW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is reset along with control so no X reaches sto_bus.
      state_q   <= IDL;
      cnt_q     <= '0;
      shr_q     <= '0;
      a_q       <= 1'b0;
      prv_adr_q <= '0;
      prv_vld_q <= 1'b0;
      run_q     <= 1'b0;
      sto_vld_q <= 1'b0;
      sto_bus_q <= '0;
      sto_lst_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (cap) begin
        prv_adr_q <= bsi_adr;
        prv_vld_q <= 1'b1;
        a_q       <= !hit;
        shr_q     <= shr_cap;
        cnt_q     <= '0;
        state_q   <= HDR;
        sto_vld_q <= 1'b1;
        sto_bus_q <= hdr_beat;
        sto_lst_q <= 1'b0;
      end else if (xfer) begin
        case (state_q)
          HDR: begin
            sto_bus_q <= beat;
            shr_q     <= shr_nxt;
            cnt_q     <= '0;
            if (a_q) begin
              state_q   <= ADR;
              sto_lst_q <= 1'b0;
            end else begin
              state_q   <= DAT;
              sto_lst_q <= (DB == 1);
            end
          end
          ADR: begin
            sto_bus_q <= beat;
            shr_q     <= shr_nxt;
            if (cnt_q == CW'(AB - 1)) begin
              state_q   <= DAT;
              cnt_q     <= '0;
              sto_lst_q <= (DB == 1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DAT: begin
            if (dat_end) begin
              state_q   <= IDL;
              cnt_q     <= '0;
              sto_vld_q <= 1'b0;
              sto_bus_q <= '0;
              sto_lst_q <= 1'b0;
            end else begin
              sto_bus_q <= beat;
              shr_q     <= shr_nxt;
              cnt_q     <= cnt_q + 1'b1;
              sto_lst_q <= (int'(cnt_q) == DB - 2);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sto_vld = sto_vld_q;
  assign sto_bus = sto_bus_q;
  assign sto_lst = sto_lst_q;

endmodule

// File: tb/tb_bus_stream_ser.sv
// Self-checking bench for bus_stream_ser: four parameterisations driven one at a
// time, every stream beat compared against a frame-level reference model.
module tb_bus_stream_ser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          sel = 0;
  logic        src_vld = 1'b0;
  logic [63:0] src_adr = '0;
  logic [63:0] src_dat = '0;
  logic        sto_rdy = 1'b0;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        vld0, vld1, vld2, vld3;
  logic        lst0, lst1, lst2, lst3;
  logic [7:0]  bus0, bus1, bus3;
  logic [15:0] bus2;

  always #5 clk = ~clk;

  bus_stream_ser #(.AW(32), .DW(32), .SW(8), .CMP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bsi_vld(src_vld && sel == 0), .bsi_adr(src_adr[31:0]),
    .bsi_dat(src_dat[31:0]), .bsi_rdy(rdy0), .sto_vld(vld0), .sto_bus(bus0),
    .sto_lst(lst0), .sto_rdy(sto_rdy));

  bus_stream_ser #(.AW(32), .DW(32), .SW(8), .CMP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bsi_vld(src_vld && sel == 1), .bsi_adr(src_adr[31:0]),
    .bsi_dat(src_dat[31:0]), .bsi_rdy(rdy1), .sto_vld(vld1), .sto_bus(bus1),
    .sto_lst(lst1), .sto_rdy(sto_rdy));

  bus_stream_ser #(.AW(64), .DW(64), .SW(16), .CMP(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bsi_vld(src_vld && sel == 2), .bsi_adr(src_adr),
    .bsi_dat(src_dat), .bsi_rdy(rdy2), .sto_vld(vld2), .sto_bus(bus2),
    .sto_lst(lst2), .sto_rdy(sto_rdy));

  bus_stream_ser #(.AW(8), .DW(8), .SW(8), .CMP(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bsi_vld(src_vld && sel == 3), .bsi_adr(src_adr[7:0]),
    .bsi_dat(src_dat[7:0]), .bsi_rdy(rdy3), .sto_vld(vld3), .sto_bus(bus3),
    .sto_lst(lst3), .sto_rdy(sto_rdy));

  typedef struct {
    logic [63:0] adr;
    logic [63:0] dat;
  } word_t;

  word_t       wq[$];
  logic [16:0] exp_q[$];
  logic [16:0] obs_log[$];
  logic [63:0] m_prv[4];
  bit          m_prv_vld[4];

  int          total = 0;
  int          bad = 0;
  int          acc_cnt, lst_cnt, cyc, first_cyc, last_cyc;
  bit          rnd_rdy, rnd_vld;
  bit          stall_p, cap_p;
  logic [16:0] beat_p;

  function automatic int aw_of(int s);
    case (s) 2: return 64; 3: return 8; default: return 32; endcase
  endfunction
  function automatic int sw_of(int s);
    return (s == 2) ? 16 : 8;
  endfunction
  function automatic bit cmp_of(int s);
    return s != 1;
  endfunction
  function automatic logic [63:0] mask(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic cur_rdy();
    case (sel) 0: return rdy0; 1: return rdy1; 2: return rdy2; default: return rdy3; endcase
  endfunction
  function automatic logic cur_vld();
    case (sel) 0: return vld0; 1: return vld1; 2: return vld2; default: return vld3; endcase
  endfunction
  function automatic logic cur_lst();
    case (sel) 0: return lst0; 1: return lst1; 2: return lst2; default: return lst3; endcase
  endfunction
  function automatic logic [15:0] cur_bus();
    case (sel)
      0:       return {8'h00, bus0};
      1:       return {8'h00, bus1};
      2:       return bus2;
      default: return {8'h00, bus3};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  // Reference model: turns an accepted word into its expected beats {lst, beat}.
  task automatic model_word(input logic [63:0] adr, input logic [63:0] dat);
    int          aw = aw_of(sel);
    int          sw = sw_of(sel);
    int          dw = aw_of(sel);
    logic [63:0] a_m = adr & mask(aw);
    bit          a;
    a = !(cmp_of(sel) && m_prv_vld[sel] && a_m == ((m_prv[sel] + 64'd1) & mask(aw)));
    m_prv[sel]     = a_m;
    m_prv_vld[sel] = 1'b1;
    exp_q.push_back({16'd0, a});
    if (a)
      for (int i = 0; i < aw / sw; i++)
        exp_q.push_back({1'b0, 16'((a_m >> (i * sw)) & mask(sw))});
    for (int i = 0; i < dw / sw; i++)
      exp_q.push_back({(i == dw / sw - 1), 16'(((dat & mask(dw)) >> (i * sw)) & mask(sw))});
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, account the
  // transfers that the next rising edge will perform.
  task automatic cycle();
    logic [16:0] beat;
    logic        r, v;
    @(negedge clk);
    cyc++;
    sto_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    src_vld = (wq.size() > 0) && (!rnd_vld || $urandom_range(0, 3) != 0);
    if (wq.size() > 0) begin
      src_adr = wq[0].adr;
      src_dat = wq[0].dat;
    end
    #1;
    r    = cur_rdy();
    v    = cur_vld();
    beat = {cur_lst(), cur_bus()};
    if (cap_p) check("lat_hdr_vld", 64'(v), 64'd1);
    if (stall_p) check("stall_hold", {v, beat}, {1'b1, beat_p});
    if (v && !(beat[16] && sto_rdy)) check("rdy_busy", 64'(r), 64'd0);
    if (v && beat[16] && sto_rdy && src_vld) check("b2b_rdy", 64'(r), 64'd1);
    cap_p = src_vld && r;
    if (cap_p) begin
      model_word(wq[0].adr, wq[0].dat);
      void'(wq.pop_front());
      acc_cnt++;
    end
    if (v && sto_rdy) begin
      obs_log.push_back(beat);
      if (beat[16]) lst_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'd1);
      else check("beat", beat, exp_q.pop_front());
    end
    stall_p = v && !sto_rdy;
    beat_p  = beat;
  endtask

  task automatic phase_start(input int s, input bit rr, input bit rv);
    @(negedge clk);
    src_vld   = 1'b0;
    sel       = s;
    rnd_rdy   = rr;
    rnd_vld   = rv;
    obs_log.delete();
    first_cyc = -1;
    last_cyc  = -1;
    stall_p   = 1'b0;
    cap_p     = 1'b0;
    acc_cnt   = 0;
    lst_cnt   = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((wq.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    cycle();
    check("drain", 64'(wq.size() + exp_q.size()), 64'd0);
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d);
    wq.push_back('{a, d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] last_a;
    logic [63:0] a;
    int          n;

    repeat (2) @(negedge clk);
    #1;
    check("rst_vld", 64'(vld0), 64'd0);
    check("rst_bus", 64'(bus0), 64'd0);
    check("rst_lst", 64'(lst0), 64'd0);
    check("rst_rdy", 64'(rdy0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("run_gate", 64'(rdy0), 64'd0);
    @(posedge clk);
    #1;
    check("run_set", 64'(rdy0), 64'd1);

    // Directed frames: full then compressed, no gap between them.
    phase_start(0, 1'b0, 1'b0);
    push(64'h10, 64'hA1B2C3D4);
    push(64'h11, 64'h01020304);
    drain(200);
    check("cmp_len", 64'(obs_log.size()), 64'd14);
    if (obs_log.size() == 14) begin
      check("cmp_adr0", 64'(obs_log[1]), 64'h10);
      check("cmp_d3_lst", 64'(obs_log[8]), 64'h1_00A1);
      check("cmp_hdr2", 64'(obs_log[9]), 64'h0);
      check("cmp_d0_2", 64'(obs_log[10]), 64'h04);
    end
    check("no_gap", 64'(last_cyc - first_cyc + 1), 64'(obs_log.size()));

    // Same words without compression.
    phase_start(1, 1'b0, 1'b0);
    push(64'h10, 64'hA1B2C3D4);
    push(64'h11, 64'h01020304);
    drain(200);
    check("nocmp_len", 64'(obs_log.size()), 64'd18);
    if (obs_log.size() == 18) check("nocmp_hdr2", 64'(obs_log[9]), 64'h1);
    check("nocmp_no_gap", 64'(last_cyc - first_cyc + 1), 64'(obs_log.size()));

    // Address wrap is sequential; a repeated address is not.
    phase_start(0, 1'b0, 1'b0);
    push(64'hFFFF_FFFF, 64'h1111_1111);
    push(64'h0, 64'h2222_2222);
    push(64'h5, 64'h3333_3333);
    push(64'h5, 64'h4444_4444);
    drain(300);
    check("wrap_len", 64'(obs_log.size()), 64'd32);
    if (obs_log.size() == 32) begin
      check("wrap_hdr", 64'(obs_log[9]), 64'h0);
      check("same_hdr", 64'(obs_log[23]), 64'h1);
    end

    // Wide configuration, random stalls and random bus idle.
    phase_start(2, 1'b1, 1'b1);
    last_a = '0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) a = '1;
      else if (i == 51) a = '0;
      else if (i > 0 && $urandom_range(0, 2) == 0) a = last_a + 64'd1;
      else a = {$urandom, $urandom};
      push(a, {$urandom, $urandom});
      last_a = a;
    end
    drain(20000);
    check("rnd_no_loss", 64'(acc_cnt), 64'd100);
    check("rnd_lst_per_frame", 64'(lst_cnt), 64'd100);

    // Single-beat address and data.
    phase_start(3, 1'b1, 1'b1);
    last_a = '0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0 && $urandom_range(0, 1) == 0) a = last_a + 64'd1;
      else a = 64'($urandom_range(0, 255));
      push(a, 64'($urandom));
      last_a = a;
    end
    drain(2000);
    check("one_beat_lst", 64'(lst_cnt), 64'd20);

    // Reset during the address beats of the third frame.
    phase_start(0, 1'b0, 1'b0);
    push(64'h100, 64'hDEAD_0001);
    push(64'h200, 64'hDEAD_0002);
    push(64'h300, 64'hDEAD_0003);
    n = 0;
    while (obs_log.size() < 20 && n < 200) begin
      cycle();
      n++;
    end
    check("rst_reach_adr", 64'(obs_log.size()), 64'd20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    src_vld = 1'b0;
    #1;
    check("mid_rst_vld", 64'(vld0), 64'd0);
    check("mid_rst_bus", 64'(bus0), 64'd0);
    check("mid_rst_lst", 64'(lst0), 64'd0);
    check("mid_rst_rdy", 64'(rdy0), 64'd0);
    exp_q.delete();
    wq.delete();
    for (int s = 0; s < 4; s++) m_prv_vld[s] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_gate", 64'(rdy0), 64'd0);
    phase_start(0, 1'b0, 1'b0);
    push(64'h301, 64'hBEEF_0004);
    drain(200);
    check("post_rst_len", 64'(obs_log.size()), 64'd9);
    if (obs_log.size() == 9) check("post_rst_hdr", 64'(obs_log[0]), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_stream_ser.md
# bus_stream_ser

Parametrised bus-to-stream serializer: the next-generation mux side of the bus mux/demux loopback. It accepts address/data bus transfers of configurable width and emits them as framed, narrow stream beats with an end-of-frame marker. Optional address compression drops the address beats when an address is the previous one plus 1. It sits between a bus source and the stream link; a matching deserializer, `bus_stream_des`, is a separate block.

## Interface
- `AW`, 32, address width; must be a multiple of `SW`
- `DW`, 32, data width; must be a multiple of `SW`
- `SW`, 8, stream width; minimum 2
- `CMP`, 1, 1 enables sequential-address compression, 0 emits the address in every frame
- `clk`  input  1  clock, all logic on rising edge
- `rst_n`  input  1  reset, asynchronous and active-low
- `bsi_vld`  input  1  bus valid
- `bsi_adr`  input  AW  bus address
- `bsi_dat`  input  DW  bus data
- `bsi_rdy`  output  1  bus ready
- `sto_vld`  output  1  stream valid
- `sto_bus`  output  SW  stream beat
- `sto_lst`  output  1  last beat of the frame
- `sto_rdy`  input  1  stream ready

## Operation
- A bus transfer is `bsi_vld & bsi_rdy`. A stream transfer is `sto_vld & sto_rdy`.
- Frame layout, in this order:
  - Header beat: `sto_bus[0]` = A. A=1 means the address is present; A=0 means address = previous frame address + 1. All other header bits are 0.
  - If A=1: AW/SW address beats, LSB first.
  - DW/SW data beats, LSB first.
  - `sto_lst` is 1 only on the final data beat.
- Compression is used only when all three hold: `CMP`=1, `prv_vld`=1, and `bsi_adr == prv_adr + 1` (modulo 2^AW).
  - Wrap-around counts as sequential: 0xFFFFFFFF followed by 0x00000000 gives A=0.
  - The comparison is made at capture time. `prv_adr` is updated on every captured word.
  - `prv_vld` is set on the first capture and cleared by reset.
- State machine: IDL -> HDR -> (ADR if A=1) -> DAT -> IDL, or DAT -> HDR when a new word is captured on the last beat.
  - A beat counter of width clog2(max(AW,DW)/SW) sequences ADR and DAT.
  - A shift register of AW+DW bits holds the captured word.
- `bsi_rdy` = run & (state==IDL | (state==DAT & last beat & `sto_rdy`)). This is combinational from `sto_rdy`, and that path is intended.
- Stream beats stay stable while `sto_vld` & !`sto_rdy`. `sto_vld` never drops before its beat transfers.

## Timing
- Reset values: `sto_vld`=0, `sto_bus`=0, `sto_lst`=0, `bsi_rdy`=0, state=IDL, `prv_vld`=0.
- `run` is a flag set on the first rising edge after `rst_n` deasserts. `bsi_rdy` is low until then.
- Latency: a word captured at edge N puts its header beat on the stream after edge N, valid in cycle N+1.
- Throughput with `sto_rdy` held high and defaults:
  - full frame: 9 beats per word;
  - compressed frame: 5 beats per word;
  - back-to-back frames have no idle cycle.
- Boundary cases:
  - Stalled `sto_rdy` mid-frame: state and beat counter hold, and `bsi_rdy` stays 0.
  - `bsi_vld` high while busy: no capture, and the input is not sampled.
  - `rst_n` asserted mid-frame: the frame is abandoned with no partial `sto_lst`. The next frame always carries A=1.
  - AW=SW or DW=SW: the ADR or DAT state lasts exactly one beat.

## Structure
- The shared package `package_bus` holds:
  - the header bit index constant `HDR_ADR = 0`;
  - the state typedef `bus_ser_st_t` {IDL, HDR, ADR, DAT};
  - a frame-length function of (AW, DW, SW, A), shared with `bus_stream_des`.
- One module, no sub-module. Parameter legality is checked with elaboration-time assertions.

## Test plan
- Reset, then words {adr 0x10, dat 0xA1B2C3D4}, {0x11, 0x01020304}, `sto_rdy`=1 -> stream 01,10,00,00,00,D4,C3,B2,A1(lst) then 00,04,03,02,01(lst).
- `CMP`=0, same stimulus -> both frames start with header 01, 9 beats each.
- Addresses 0xFFFFFFFF then 0x00000000 -> second header 00 (wrap counts as sequential); addresses 5 then 5 -> second header 01.
- Random `sto_rdy` (50%) over 100 random words, `SW`=16, `AW`=`DW`=64 -> beats stable under stall, `sto_lst` once per frame, golden model matches, no bus word lost or duplicated.
- `rst_n` low during the ADR beats of frame 3 -> outputs return to reset values immediately; the next frame after release has header 01.
- Back-to-back words with `sto_rdy`=1 -> `bsi_rdy` high in the same cycle as every `sto_lst` transfer, giving zero gap between frames.
